// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider with start/busy/done handshake; ports clk, rst, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero; optional two's-complement mode via DIV_SIGNED_EN
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, FIN} state_t;
`ifdef DIV_SIGNED_EN
  localparam state_t AFTER_RUN = SIGN;
`else
  localparam state_t AFTER_RUN = FIN;
`endif
  state_t state, state_n;
  logic [2*WIDTH:0] p, p_run;
  logic [WIDTH-1:0] d, dd_mag, dv_mag;
  logic [WIDTH:0] t;
  logic [CNT_W-1:0] cnt;
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
`endif
  assign busy = state != IDLE;
  // trial subtract on the shifted partial remainder; a set top bit means it went negative
  always_comb begin
    t = p[2*WIDTH-1:WIDTH-1] - {1'b0, d};
    p_run = t[WIDTH] ? p << 1 : {t, p[WIDTH-2:0], 1'b1};
  end
  always_comb begin
    state_n = state == IDLE ? (start ? (divisor == '0 ? FIN : RUN) : IDLE)
            : state == RUN  ? (cnt == CNT_W'(1) ? AFTER_RUN : RUN)
            : state == SIGN ? FIN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      d <= '0;
      cnt <= '0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // a zero divisor keeps the raw dividend so it can be returned as the remainder
          p <= {{(WIDTH+1){1'b0}}, divisor == '0 ? dividend : dd_mag};
          d <= dv_mag;
          cnt <= CNT_W'(WIDTH);
          div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
`endif
        end
        RUN: begin
          p <= p_run;
          cnt <= cnt - CNT_W'(1);
        end
`ifdef DIV_SIGNED_EN
        SIGN: p <= {1'b0, neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH], neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]};
`endif
        FIN: begin
          done <= 1'b1;
          div_by_zero <= d == '0;
          quotient <= d == '0 ? '1 : p[WIDTH-1:0];
          remainder <= d == '0 ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference model
module tb_seq_divider;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, failures = 0;
  logic [W-1:0] eq, er;
  logic ez;
  int elat;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
`ifdef DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    elat = b == 0 ? 1 : W + 2;
`else
    sa = int'(a);
    sb = int'(b);
    elat = b == 0 ? 1 : W + 1;
`endif
    ez = b == 0;
    eq = b == 0 ? '1 : W'(sa / sb);
    er = b == 0 ? a : W'(sa % sb);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    model(a, b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    step;
    start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_done", done, 1'b0);
    chk("accept_dbz_clear", div_by_zero, 1'b0);
  endtask
  task automatic wait_done(input string tag, input int intrude);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      if (n == intrude) begin
        start = 1'b1;
        dividend = 50;
        divisor = 5;
      end
      if (n == intrude + 1) start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      step;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask
  initial begin
    logic [W-1:0] a, b;
    logic seen;
    repeat (2) step;
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 16'h0);
    chk("rst_r", remainder, 16'h0);
    chk("rst_dbz", div_by_zero, 1'b0);
    launch(100, 7);
    wait_done("d100_7", -1);
    chk("d100_7_qc", quotient, 16'd14);
    chk("d100_7_rc", remainder, 16'd2);
    step;
    chk("pulse_once", done, 1'b0);
    chk("hold_q", quotient, 16'd14);
    launch(16'hFFFF, 1);
    wait_done("dffff_1", -1);
    chk("dffff_1_qc", quotient, 16'hFFFF);
    launch(5, 9);
    wait_done("d5_9", -1);
    chk("d5_9_rc", remainder, 16'd5);
    launch(16'h1234, 0);
    wait_done("dbz", -1);
    chk("dbz_qc", quotient, 16'hFFFF);
    chk("dbz_rc", remainder, 16'h1234);
    launch(100, 7);
    wait_done("ignore", 4);
    chk("ignore_qc", quotient, 16'd14);
    launch(50, 5);
    wait_done("b2b", -1);
    chk("b2b_qc", quotient, 16'd10);
    launch(1000, 3);
    repeat (7) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 16'h0);
    chk("abort_r", remainder, 16'h0);
    chk("abort_dbz", div_by_zero, 1'b0);
    seen = 1'b0;
    repeat (25) begin
      step;
      seen |= done;
    end
    chk("abort_no_done", seen, 1'b0);
    launch(9, 3);
    wait_done("d9_3", -1);
    chk("d9_3_qc", quotient, 16'd3);
`ifdef DIV_SIGNED_EN
    launch(16'hFF9C, 7);
    wait_done("sgn", -1);
    chk("sgn_qc", quotient, 16'hFFF2);
    chk("sgn_rc", remainder, 16'hFFFE);
    launch(16'h8000, 16'hFFFF);
    wait_done("sgn_ovf", -1);
    chk("sgn_ovf_qc", quotient, 16'h8000);
    chk("sgn_ovf_rc", remainder, 16'h0);
`endif
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 5 == 0) b = W'($urandom_range(0, 2));
      if (i % 5 == 1) b = a;
      if (i % 5 == 3) a = a >> 8;
      launch(a, b);
      wait_done("rand", -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
